// File: rtl/pri_dec_96_7_if.sv
// Handshake and data bundle for the 96-entry index-to-one-hot decoder.
// The slave side is the decoder itself; the master side is the consumer
// that returns slot indices and collects the release bitmap.
interface pri_dec_96_7_if;
    // Input side: returned slot index.
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_idx;

    // Output side: decoded slot.
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_onehot;
    logic [3:0]  out_grp;
    logic [3:0]  out_ofs;
    logic        out_err;

    // Release bitmap owned by the free-list logic.
    logic        acc_clr;
    logic [95:0] acc_map;

    modport master (
        output in_valid,
        input  in_ready,
        output in_idx,
        input  out_valid,
        output out_ready,
        input  out_onehot,
        input  out_grp,
        input  out_ofs,
        input  out_err,
        output acc_clr,
        input  acc_map
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_idx,
        output out_valid,
        input  out_ready,
        output out_onehot,
        output out_grp,
        output out_ofs,
        output out_err,
        input  acc_clr,
        output acc_map
    );
endinterface

// File: rtl/pri_dec_96_7.sv
// Two-stage 7-bit index to 96-bit one-hot decoder with valid/ready flow
// control and a running bitmap of every released slot.
//   S1: registers the index split into group (idx/12) and offset (idx%12),
//       found by comparing against the multiples of 12.
//   S2: registers the one-hot mask built from group/offset; drives outputs.
module pri_dec_96_7 #(
    parameter bit SIM_EMULATE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    pri_dec_96_7_if.slave bus
);

    localparam int unsigned N_GRP    = 8;
    localparam int unsigned GRP_SIZE = 12;
    localparam int unsigned N_SLOT   = N_GRP * GRP_SIZE;

    // Decoded location of one index.
    typedef struct packed {
        logic [3:0] grp;
        logic [3:0] ofs;
        logic       err;
    } loc_t;

    // Kept only so the decoder shares a parameter list with the encoder.
    if (SIM_EMULATE) begin : g_sim_emulate
    end

    // Split an index into group/offset by range compare; indices past the
    // last slot map to the sentinel group 8 with offset 0.
    function automatic loc_t locate(input logic [6:0] idx);
        loc_t       r;
        logic [6:0] base;
        // NOTE: every field gets a default before any conditional update, so
        // no path through this logic can leave a bit unassigned (no latch).
        r    = '0;
        base = '0;
        if (idx >= 7'(N_SLOT)) begin
            r.err = 1'b1;
            r.grp = 4'(N_GRP);
        end else begin
            for (int g = 1; g < int'(N_GRP); g++) begin
                if (idx >= 7'(g * GRP_SIZE)) begin
                    r.grp = 4'(g);
                    base  = 7'(g * GRP_SIZE);
                end
            end
            r.ofs = 4'(idx - base);
        end
        return r;
    endfunction

    // Place a single bit at position ofs inside the 12-bit slice of grp.
    function automatic logic [95:0] expand(input loc_t l);
        logic [95:0] m;
        m = '0;
        if (!l.err) begin
            for (int g = 0; g < int'(N_GRP); g++) begin
                if (l.grp == 4'(g)) begin
                    m[g*GRP_SIZE +: GRP_SIZE] = 12'b1 << l.ofs;
                end
            end
        end
        return m;
    endfunction

    // Pipeline state.
    logic        s1_valid_q;
    loc_t        s1_loc_q;
    logic        s2_valid_q;
    loc_t        s2_loc_q;
    logic [95:0] s2_onehot_q;
    logic [95:0] acc_q;

    // Handshake terms.
    logic        in_ready;
    logic        in_xfer;
    logic        out_xfer;
    logic        s2_take;
    loc_t        in_loc;

    // S1 can accept whenever it is empty or its content moves on to S2;
    // that is true when S2 is empty or S2 is being drained this cycle.
    assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || bus.out_ready);
    assign in_xfer  = bus.in_valid && in_ready;
    assign out_xfer = s2_valid_q && bus.out_ready;
    assign s2_take  = !s2_valid_q || bus.out_ready;
    assign in_loc   = locate(bus.in_idx);

    // S1 valid bit: refill from the input whenever S1 is free to advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    // S1 payload: captured on input transfers only.
    always_ff @(posedge clk) begin
        // NOTE: the payload is qualified by s1_valid_q, so it carries no
        // reset; only the valid bit has to be cleared.
        if (in_xfer) begin
            s1_loc_q <= in_loc;
        end
    end

    // S2: load from S1 when empty or draining; hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_loc_q    <= '0;
            s2_onehot_q <= '0;
        end else if (s2_take) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_loc_q    <= s1_loc_q;
                s2_onehot_q <= expand(s1_loc_q);
            end
        end
    end

    // Release bitmap: a clear coinciding with a delivery keeps that delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (bus.acc_clr && out_xfer) begin
            acc_q <= s2_onehot_q;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end else if (out_xfer) begin
            acc_q <= acc_q | s2_onehot_q;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_onehot = s2_onehot_q;
    assign bus.out_grp    = s2_loc_q.grp;
    assign bus.out_ofs    = s2_loc_q.ofs;
    assign bus.out_err    = s2_loc_q.err;
    assign bus.acc_map    = acc_q;

endmodule

// File: doc/pri_dec_96_7.md
# pri_dec_96_7

Pipelined 7-bit index to 96-bit one-hot decoder with a valid/ready handshake and a running release bitmap. It is the inverse of the 96-entry, 7-bit priority encoder used for slot and tag selection. Consumers return slot indices through this block. It rebuilds the one-hot mask, the 12-entry group number and the in-group offset, and accumulates released slots into a bitmap that the free-list logic reads and clears.

## Interface
- SIM_EMULATE, 1'b0, carried for parity with the encoder family; has no functional effect.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  in_idx is valid this cycle.
- in_ready  out  1  the block can accept in_idx this cycle.
- in_idx  in  7  slot index; 0..95 are legal, 96..127 are out of range.
- out_valid  out  1  the output fields are valid.
- out_ready  in  1  the downstream block accepts the output this cycle.
- out_onehot  out  96  decoded mask; bit in_idx is set.
- out_grp  out  4  group number, in_idx/12 (0..7); 8 when out of range.
- out_ofs  out  4  offset within the group, in_idx%12 (0..11); 0 when out of range.
- out_err  out  1  the index was out of range (>=96).
- acc_clr  in  1  clear the accumulated bitmap.
- acc_map  out  96  OR of every out_onehot delivered since the last clear or reset.

## Operation
- Two register stages, S1 and S2. Each stage has its own valid bit.
- An input transfer happens when in_valid && in_ready.
- An output transfer happens when out_valid && out_ready.
- S1 captures in_idx and computes grp/ofs by range compare against the multiples of 12. No divider is used.
  - idx >= 96 gives grp=8, ofs=0, err=1.
- S2 registers the one-hot mask, which is 12'b1 << ofs placed in slice [12*grp +: 12], together with grp, ofs and err.
  - When err=1, onehot is all zeros.
- S2 is driven by out_valid/out_onehot/out_grp/out_ofs/out_err.
- Stall rules:
  - S2 loads from S1 when S2 is empty or an output transfer happens.
  - S1 loads from the input when S1 is empty or S1 moves into S2.
  - in_ready = !rst && (!s1_valid || !s2_valid || out_ready).
- While out_valid=1 && out_ready=0, all output fields hold stable.
- Accumulator update, in priority order:
  - acc_clr with an output transfer in the same cycle: acc_map <= out_onehot.
  - acc_clr alone: acc_map <= 0.
  - output transfer alone: acc_map <= acc_map | out_onehot.
- An out-of-range entry contributes nothing to acc_map, since its onehot is zero.
- Repeated release of the same index is idempotent in acc_map.

## Timing
- Reset values: out_valid=0, out_onehot=0, out_grp=0, out_ofs=0, out_err=0, acc_map=0, S1 empty.
  - in_ready=0 while rst=1 and becomes 1 in the first cycle after rst falls.
- Latency: an input transfer at cycle N gives out_valid=1 at N+2 when there is no stall.
- Throughput is one transfer per cycle with out_ready held high.
- Backpressure: with out_ready low, the block absorbs up to two entries. in_ready falls in the cycle after the second one is accepted.
- When out_ready rises, in_ready is 1 in the same cycle, because it combinationally depends on out_ready. No bubble is inserted.
- acc_map reflects a transfer at cycle N in cycle N+1.
- acc_clr takes effect in the next cycle.
- rst in mid-operation drops all in-flight entries without producing output and clears acc_map. There is no partial output.
- in_idx is sampled only on an input transfer. Its value while in_valid=0 is ignored.

## Test plan
- Reset, then in_idx=0 with out_ready=1 -> 2 cycles later out_onehot=bit0, grp=0, ofs=0, err=0; acc_map=96'h1 the next cycle.
- Stream 11,12,23,24,95 back-to-back with out_ready=1 -> five consecutive outputs with no gaps:
  - grp/ofs = 0/11, 1/0, 1/11, 2/0, 7/11.
  - each onehot has exactly one bit set, at the matching index.
- in_idx=96, then 127 -> out_err=1, onehot=0, grp=8, ofs=0; acc_map unchanged.
- Hold out_ready=0 for 6 cycles with in_valid=1 on indices 5,6,7 ->
  - in_ready falls after 5 and 6 are accepted;
  - 5 is held stable at the output;
  - after release the outputs are 5, 6, 7 in order, with none lost or duplicated.
- Release 3, 50, 95, then assert acc_clr in the same cycle as the transfer of 40 -> acc_map=bit40 only.
  - A following acc_clr alone gives acc_map=0.
- Assert rst with two entries in flight -> no out_valid after reset and acc_map=0.
  - A new in_idx=17 then gives grp=1, ofs=5 at N+2.
